// File: rtl/yutorina_banked_gpr.sv
// Banked general-purpose register file for the decode stage.
// Two combinational read ports with write-to-read bypass, one pipeline write
// port, a current-bank register, and a background engine that copies one
// bank into another for interrupt context save/restore.
// Register 0 of every bank is never written and always reads as zero.

module yutorina_banked_gpr #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BANK_W = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [ADDR_W-1:0] r_addr1,
    output logic [DATA_W-1:0] r_data1,
    input  logic [ADDR_W-1:0] r_addr2,
    output logic [DATA_W-1:0] r_data2,
    input  logic              we_,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              bank_we_,
    input  logic [BANK_W-1:0] bank_in,
    output logic [BANK_W-1:0] cur_bank,
    input  logic              copy_req,
    input  logic [BANK_W-1:0] copy_src,
    input  logic [BANK_W-1:0] copy_dst,
    output logic              copy_busy,
    output logic              copy_done
);

    localparam int GPR_NUM = 2 ** ADDR_W;
    localparam int NBANK   = 2 ** BANK_W;

    typedef enum logic [1:0] {
        IDLE,
        COPY,
        DONE
    } copy_state_t;

    copy_state_t       state;
    logic [BANK_W-1:0] src_q;
    logic [BANK_W-1:0] dst_q;
    logic [ADDR_W-1:0] ptr;

    logic [DATA_W-1:0] regs [NBANK][GPR_NUM];

    logic              commit;
    logic              copy_active;
    logic [DATA_W-1:0] copy_data;

    // A flushed write or a write to register 0 is dropped entirely, so it
    // must neither update storage nor feed the bypass path.
    assign commit      = !we_ && (w_addr != '0) && !flush;
    assign copy_active = (state == COPY);

    // The copy source is read before the edge, so a pipeline write to the
    // source register at the current pointer lands after the old value has
    // already been copied.
    assign copy_data = regs[src_q][ptr];

    // Storage update: the pipeline write takes priority over the copy engine
    // when both target the same register in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < NBANK; b++) begin
                for (int a = 0; a < GPR_NUM; a++) begin
                    regs[b][a] <= '0;
                end
            end
        end else begin
            for (int b = 0; b < NBANK; b++) begin
                for (int a = 0; a < GPR_NUM; a++) begin
                    if (commit && (cur_bank == BANK_W'(b)) && (w_addr == ADDR_W'(a))) begin
                        regs[b][a] <= w_data;
                    end else if (copy_active && (dst_q == BANK_W'(b)) && (ptr == ADDR_W'(a))) begin
                        regs[b][a] <= copy_data;
                    end
                end
            end
        end
    end

    // Read port 1: zero register, then bypass of this cycle's commit, then storage.
    always_comb begin
        r_data1 = '0;
        if (r_addr1 != '0) begin
            if (commit && (w_addr == r_addr1)) begin
                r_data1 = w_data;
            end else begin
                r_data1 = regs[cur_bank][r_addr1];
            end
        end
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        r_data2 = '0;
        if (r_addr2 != '0) begin
            if (commit && (w_addr == r_addr2)) begin
                r_data2 = w_data;
            end else begin
                r_data2 = regs[cur_bank][r_addr2];
            end
        end
    end

    // Current bank register; reads and writes in the switching cycle still
    // see the old bank because the new value only appears after the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_bank <= '0;
        end else if (!bank_we_) begin
            cur_bank <= bank_in;
        end
    end

    // Copy engine: walks registers 1..GPR_NUM-1 once, then pulses done for a
    // single cycle. Requests arriving while busy are dropped, not queued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            ptr       <= '0;
            copy_busy <= 1'b0;
            copy_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    copy_done <= 1'b0;
                    if (copy_req) begin
                        src_q     <= copy_src;
                        dst_q     <= copy_dst;
                        ptr       <= ADDR_W'(1);
                        state     <= COPY;
                        copy_busy <= 1'b1;
                    end
                end
                COPY: begin
                    copy_busy <= 1'b1;
                    if (ptr == '1) begin
                        state     <= DONE;
                        copy_done <= 1'b1;
                    end else begin
                        ptr <= ptr + ADDR_W'(1);
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    copy_busy <= 1'b0;
                    copy_done <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    copy_busy <= 1'b0;
                    copy_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_yutorina_banked_gpr.sv
// Directed bench for yutorina_banked_gpr: reset state, bypass and flush,
// register-0 protection, bank copy timing, copy/pipeline collisions and
// reset in the middle of a copy.

module tb_yutorina_banked_gpr;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int BANK_W = 1;

    logic              clk;
    logic              rst;
    logic              flush;
    logic [ADDR_W-1:0] r_addr1;
    logic [DATA_W-1:0] r_data1;
    logic [ADDR_W-1:0] r_addr2;
    logic [DATA_W-1:0] r_data2;
    logic              we_;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              bank_we_;
    logic [BANK_W-1:0] bank_in;
    logic [BANK_W-1:0] cur_bank;
    logic              copy_req;
    logic [BANK_W-1:0] copy_src;
    logic [BANK_W-1:0] copy_dst;
    logic              copy_busy;
    logic              copy_done;

    int test_count;
    int fail_count;

    yutorina_banked_gpr #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .BANK_W(BANK_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .r_addr1  (r_addr1),
        .r_data1  (r_data1),
        .r_addr2  (r_addr2),
        .r_data2  (r_data2),
        .we_      (we_),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .bank_we_ (bank_we_),
        .bank_in  (bank_in),
        .cur_bank (cur_bank),
        .copy_req (copy_req),
        .copy_src (copy_src),
        .copy_dst (copy_dst),
        .copy_busy(copy_busy),
        .copy_done(copy_done)
    );

    // Free-running 10-time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and leave inputs/outputs settled well away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the pipeline write port and let the combinational outputs settle.
    task automatic applyStimulus(input logic we_n, input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] data, input logic fl);
        we_    = we_n;
        w_addr = addr;
        w_data = data;
        flush  = fl;
        #1;
    endtask

    // One comparison: counts it, and on mismatch counts and reports the failure.
    task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                               input logic [DATA_W-1:0] expected);
        test_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Read one register through both ports and check each.
    task automatic readCheck(input string tag, input int addr, input logic [DATA_W-1:0] expected);
        r_addr1 = ADDR_W'(addr);
        r_addr2 = ADDR_W'(addr);
        #1;
        checkOutput($sformatf("%s_p1_r%0d", tag, addr), r_data1, expected);
        checkOutput($sformatf("%s_p2_r%0d", tag, addr), r_data2, expected);
    endtask

    // Load cur_bank over one edge.
    task automatic switchBank(input logic [BANK_W-1:0] bank);
        bank_we_ = 1'b0;
        bank_in  = bank;
        tick();
        bank_we_ = 1'b1;
    endtask

    initial begin
        int busy_cycles;
        int done_count;
        int guard;

        test_count = 0;
        fail_count = 0;
        rst      = 1'b0;
        flush    = 1'b0;
        r_addr1  = '0;
        r_addr2  = '0;
        we_      = 1'b1;
        w_addr   = '0;
        w_data   = '0;
        bank_we_ = 1'b1;
        bank_in  = '0;
        copy_req = 1'b0;
        copy_src = '0;
        copy_dst = '0;

        // ---- 1: reset state ----
        tick();
        tick();
        rst = 1'b1;
        tick();
        checkOutput("rst_busy", 32'(copy_busy), 32'd0);
        checkOutput("rst_done", 32'(copy_done), 32'd0);
        checkOutput("rst_bank", 32'(cur_bank), 32'd0);
        for (int i = 0; i < 32; i++) readCheck("rst_b0", i, 32'd0);
        switchBank(1'b1);
        checkOutput("bank_sw1", 32'(cur_bank), 32'd1);
        for (int i = 0; i < 32; i++) readCheck("rst_b1", i, 32'd0);
        switchBank(1'b0);
        checkOutput("bank_sw0", 32'(cur_bank), 32'd0);

        // ---- 2: bypass and flush ----
        r_addr1 = 5'd5;
        r_addr2 = 5'd6;
        applyStimulus(1'b0, 5'd5, 32'hDEAD_BEEF, 1'b0);
        checkOutput("bypass_same_cycle", r_data1, 32'hDEAD_BEEF);
        checkOutput("bypass_other_addr", r_data2, 32'd0);
        tick();
        applyStimulus(1'b1, 5'd5, 32'd0, 1'b0);
        checkOutput("write_after_edge", r_data1, 32'hDEAD_BEEF);
        r_addr2 = 5'd5;
        applyStimulus(1'b0, 5'd5, 32'h1234_5678, 1'b1);
        checkOutput("flush_no_bypass_p1", r_data1, 32'hDEAD_BEEF);
        checkOutput("flush_no_bypass_p2", r_data2, 32'hDEAD_BEEF);
        tick();
        applyStimulus(1'b1, 5'd0, 32'd0, 1'b0);
        checkOutput("flush_no_write", r_data1, 32'hDEAD_BEEF);

        // ---- 3: register 0 is never written ----
        r_addr1 = 5'd0;
        applyStimulus(1'b0, 5'd0, 32'd1, 1'b0);
        checkOutput("r0_no_bypass", r_data1, 32'd0);
        tick();
        applyStimulus(1'b1, 5'd0, 32'd0, 1'b0);
        checkOutput("r0_no_write", r_data1, 32'd0);

        // ---- 4: fill bank 0 and copy it into bank 1 ----
        for (int i = 1; i < 32; i++) begin
            applyStimulus(1'b0, ADDR_W'(i), 32'(i * 3), 1'b0);
            tick();
        end
        applyStimulus(1'b1, 5'd0, 32'd0, 1'b0);
        readCheck("fill_b0", 5, 32'd15);
        readCheck("fill_b0", 31, 32'd93);

        copy_req = 1'b1;
        copy_src = 1'b0;
        copy_dst = 1'b1;
        tick();
        copy_req = 1'b0;
        busy_cycles = 0;
        done_count  = 0;
        guard       = 0;
        while (copy_busy && guard < 100) begin
            busy_cycles++;
            if (copy_done) done_count++;
            bank_we_ = (busy_cycles == 1) ? 1'b0 : 1'b1;
            bank_in  = 1'b1;
            if (busy_cycles == 10) begin
                copy_req = 1'b1;
                copy_src = 1'b1;
                copy_dst = 1'b0;
            end else begin
                copy_req = 1'b0;
            end
            tick();
            guard++;
        end
        bank_we_ = 1'b1;
        copy_req = 1'b0;
        checkOutput("copy_busy_cycles", 32'(busy_cycles), 32'd32);
        checkOutput("copy_done_pulses", 32'(done_count), 32'd1);
        checkOutput("bank_during_copy", 32'(cur_bank), 32'd1);
        done_count = 0;
        for (int i = 0; i < 4; i++) begin
            if (copy_busy || copy_done) done_count++;
            tick();
        end
        checkOutput("busy_req_ignored", 32'(done_count), 32'd0);
        for (int i = 0; i < 32; i++) readCheck("copy_b1", i, 32'(i * 3));

        // ---- 5: collisions during a copy ----
        copy_req = 1'b1;
        copy_src = 1'b0;
        copy_dst = 1'b1;
        tick();
        copy_req = 1'b0;
        for (int p = 1; p < 32; p++) begin
            checkOutput($sformatf("coll_busy_p%0d", p), 32'(copy_busy), 32'd1);
            bank_we_ = 1'b1;
            we_      = 1'b1;
            if (p == 3) begin
                we_      = 1'b0;
                w_addr   = 5'd3;
                w_data   = 32'hAAAA_5555;
                bank_we_ = 1'b0;
                bank_in  = 1'b0;
            end else if (p == 10) begin
                we_    = 1'b0;
                w_addr = 5'd31;
                w_data = 32'hCAFE_F00D;
            end else if (p == 11) begin
                we_    = 1'b0;
                w_addr = 5'd11;
                w_data = 32'h1111_1111;
            end else if (p == 12) begin
                bank_we_ = 1'b0;
                bank_in  = 1'b1;
            end
            tick();
        end
        we_      = 1'b1;
        bank_we_ = 1'b1;
        #1;
        checkOutput("coll_done_pulse", 32'(copy_done), 32'd1);
        checkOutput("coll_bank", 32'(cur_bank), 32'd1);
        tick();
        checkOutput("coll_idle_busy", 32'(copy_busy), 32'd0);
        checkOutput("coll_idle_done", 32'(copy_done), 32'd0);
        readCheck("coll_dst_wins", 3, 32'hAAAA_5555);
        readCheck("coll_src_ahead", 31, 32'hCAFE_F00D);
        readCheck("coll_src_at_ptr", 11, 32'd33);
        readCheck("coll_plain", 10, 32'd30);
        readCheck("coll_plain", 20, 32'd60);
        switchBank(1'b0);
        readCheck("coll_src_b0", 11, 32'h1111_1111);
        switchBank(1'b1);

        // ---- 6: reset in the middle of a copy ----
        copy_req = 1'b1;
        copy_src = 1'b1;
        copy_dst = 1'b0;
        tick();
        copy_req = 1'b0;
        for (int p = 1; p < 12; p++) tick();
        #2;
        rst = 1'b0;
        r_addr1 = 5'd3;
        #1;
        checkOutput("midrst_busy", 32'(copy_busy), 32'd0);
        checkOutput("midrst_done", 32'(copy_done), 32'd0);
        checkOutput("midrst_bank", 32'(cur_bank), 32'd0);
        checkOutput("midrst_read", r_data1, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        done_count = 0;
        for (int i = 0; i < 40; i++) begin
            if (copy_busy || copy_done) done_count++;
            tick();
        end
        checkOutput("midrst_no_resume", 32'(done_count), 32'd0);
        for (int i = 0; i < 32; i++) readCheck("midrst_b0", i, 32'd0);
        switchBank(1'b1);
        for (int i = 0; i < 32; i++) readCheck("midrst_b1", i, 32'd0);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
